// File: rtl/lcd_text_sequencer_if.sv
// Host-write, refresh and LCD-executor signals of lcd_text_sequencer, bundled with
// master (host/executor side) and slave (sequencer side) modports.
interface lcd_text_sequencer_if;
  // Host side: WR_EN writes WR_DATA to buffer slot WR_ADDR on the clock edge.
  // REFRESH is a level sampled every cycle and has no ready.
  logic       WR_EN;
  logic [4:0] WR_ADDR;
  logic [7:0] WR_DATA;
  logic       REFRESH;

  // Executor handshake: a one-cycle EXE_RDY pulse means the executor has parked.
  // The sequencer answers one cycle later. It holds a command on EXE_OP/EXE_DATA
  // for exactly one cycle (its "valid" cycle), and the executor consumes it at the
  // end of that cycle. Outside that cycle EXE_OP carries the idle opcode.
  logic       EXE_RDY;
  logic       EXE_ENB;
  logic [3:0] EXE_OP;
  logic [7:0] EXE_DATA;
  logic       BUSY;
  logic       DONE;

  modport master (
    output WR_EN, WR_ADDR, WR_DATA, REFRESH, EXE_RDY,
    input  EXE_ENB, EXE_OP, EXE_DATA, BUSY, DONE
  );

  modport slave (
    input  WR_EN, WR_ADDR, WR_DATA, REFRESH, EXE_RDY,
    output EXE_ENB, EXE_OP, EXE_DATA, BUSY, DONE
  );
endinterface

// File: rtl/lcd_text_sequencer.sv
// lcd_text_sequencer: 2x16 frame buffer replayed as LCD executor commands on REFRESH.
// Define LCD_SEQ_CLEAR_EN to prefix every sequence with a CLEAR command.
module lcd_text_sequencer (
  input  logic                       CLK,
  input  logic                       RST,
  lcd_text_sequencer_if.slave        bus_if,
  output logic [1:0]                 dbg_state_o,
  output logic [5:0]                 dbg_step_o,
  output logic                       dbg_pending_o,
  output logic                       dbg_parked_o
);

  localparam logic [3:0] IDLE_OP   = 4'hE;
  localparam logic [7:0] FILL_CHAR = 8'h20;
  localparam logic [3:0] OP_CLEAR  = 4'h0;
  localparam logic [3:0] OP_WRITE  = 4'h1;
  localparam logic [3:0] OP_SETDD  = 4'h3;

`ifdef LCD_SEQ_CLEAR_EN
  localparam logic [5:0] NUM_STEPS = 6'd35;
  localparam logic [5:0] BODY_OFS  = 6'd1;
`else
  localparam logic [5:0] NUM_STEPS = 6'd34;
  localparam logic [5:0] BODY_OFS  = 6'd0;
`endif

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_IDLE    = 2'd1,
    S_PRESENT = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       busy_q, busy_d;
  logic       pending_q, pending_d;
  logic       parked_q, parked_d;
  logic       done_q, done_d;
  logic       enb_q;
  logic [5:0] step_q, step_d;
  logic [3:0] op_q, op_d;
  logic [7:0] data_q, data_d;
  logic [7:0] buf_q [32];

  logic [5:0] load_idx;
  logic [5:0] body_idx;
  logic [4:0] char_idx;
  logic [3:0] load_op;
  logic [7:0] load_data;
  logic       pending_req;

  // Only an in-flight sequence loads step_q; every other load starts a sequence.
  always_comb begin
    load_idx  = (state_q == S_WAIT && busy_q && step_q < NUM_STEPS) ? step_q : 6'd0;
    body_idx  = load_idx - BODY_OFS;
    char_idx  = 5'd0;
    load_op   = OP_WRITE;
    load_data = FILL_CHAR;
`ifdef LCD_SEQ_CLEAR_EN
    if (load_idx == 6'd0) begin
      load_op   = OP_CLEAR;
      load_data = 8'h00;
    end else
`endif
    if (body_idx == 6'd0) begin
      load_op   = OP_SETDD;
      load_data = 8'h00;
    end else if (body_idx == 6'd17) begin
      load_op   = OP_SETDD;
      load_data = 8'h40;
    end else begin
      // Mod-32 arithmetic maps body 1..16 to 0..15 and 18..33 to 16..31.
      load_op   = OP_WRITE;
      char_idx  = (body_idx <= 6'd16) ? (body_idx[4:0] - 5'd1) : (body_idx[4:0] - 5'd2);
      load_data = buf_q[char_idx];
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    pending_d   = pending_q;
    parked_d    = parked_q;
    step_d      = step_q;
    op_d        = op_q;
    data_d      = data_q;
    done_d      = 1'b0;
    pending_req = pending_q | bus_if.REFRESH;

    case (state_q)
      S_WAIT: begin
        op_d = IDLE_OP;
        if (bus_if.REFRESH) pending_d = 1'b1;
        if (bus_if.EXE_RDY) begin
          parked_d = 1'b1;
          if (busy_q && step_q < NUM_STEPS) begin
            op_d    = load_op;
            data_d  = load_data;
            state_d = S_PRESENT;
          end else begin
            if (busy_q) begin
              done_d = 1'b1;
              busy_d = 1'b0;
            end
            // A request raised in this very cycle is merged into the restart.
            if (pending_req) begin
              pending_d = 1'b0;
              busy_d    = 1'b1;
              step_d    = 6'd0;
              op_d      = load_op;
              data_d    = load_data;
              state_d   = S_PRESENT;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end

      S_IDLE: begin
        op_d = IDLE_OP;
        if (bus_if.REFRESH) begin
          busy_d  = 1'b1;
          step_d  = 6'd0;
          op_d    = load_op;
          data_d  = load_data;
          state_d = S_PRESENT;
        end
      end

      S_PRESENT: begin
        if (bus_if.REFRESH) pending_d = 1'b1;
        op_d     = IDLE_OP;
        parked_d = 1'b0;
        step_d   = (step_q == 6'h3F) ? step_q : step_q + 6'd1;
        state_d  = S_WAIT;
      end

      default: begin
        op_d    = IDLE_OP;
        state_d = S_WAIT;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= S_WAIT;
      busy_q    <= 1'b0;
      pending_q <= 1'b0;
      parked_q  <= 1'b0;
      done_q    <= 1'b0;
      enb_q     <= 1'b0;
      step_q    <= 6'd0;
      op_q      <= IDLE_OP;
      data_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
      parked_q  <= parked_d;
      done_q    <= done_d;
      enb_q     <= 1'b1;
      step_q    <= step_d;
      op_q      <= op_d;
      data_q    <= data_d;
    end
  end

  // Host write port runs regardless of FSM state.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < 32; i++) buf_q[i] <= FILL_CHAR;
    end else if (bus_if.WR_EN) begin
      buf_q[bus_if.WR_ADDR] <= bus_if.WR_DATA;
    end
  end

  assign bus_if.EXE_ENB  = enb_q;
  assign bus_if.EXE_OP   = op_q;
  assign bus_if.EXE_DATA = data_q;
  assign bus_if.BUSY     = busy_q;
  assign bus_if.DONE     = done_q;

  assign dbg_state_o   = state_q;
  assign dbg_step_o    = step_q;
  assign dbg_pending_o = pending_q;
  assign dbg_parked_o  = parked_q;

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Bench for lcd_text_sequencer: executor model with random latency feeds a scoreboard
// whose expected command stream is built from a model of the 2x16 screen.
`timescale 1ns/1ps
module tb_lcd_text_sequencer;

  localparam logic [3:0]  IDLE_OP    = 4'hE;
  localparam logic [11:0] MARK       = 12'hF00;
  localparam logic [1:0]  ST_IDLE    = 2'd1;
  localparam logic [1:0]  ST_PRESENT = 2'd2;
`ifdef LCD_SEQ_CLEAR_EN
  localparam int N_STEPS = 35;
`else
  localparam int N_STEPS = 34;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] dbg_state;
  logic [5:0] dbg_step;
  logic       dbg_pending;
  logic       dbg_parked;

  lcd_text_sequencer_if bus_if();

  lcd_text_sequencer dut (
    .CLK           (clk),
    .RST           (rst_n),
    .bus_if        (bus_if),
    .dbg_state_o   (dbg_state),
    .dbg_step_o    (dbg_step),
    .dbg_pending_o (dbg_pending),
    .dbg_parked_o  (dbg_parked)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  mb [32];
  int          cmd_cnt  = 0;
  int          done_cnt = 0;
  int          dly_min  = 2;
  int          dly_max  = 6;
  int          ex_mode  = 0;
  int          ex_cnt   = 0;
  logic [7:0]  ex_data  = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- executor model + monitor ----------------
  // mode 0: initialising, 1: parked (accepts any non-idle opcode), 2: executing.
  always @(negedge clk) begin
    logic [11:0] e;
    if (bus_if.DONE) begin
      done_cnt++;
      check("done_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("done_position", e[11:8], 4'hF);
        if (e[11:8] == 4'hF) check("busy_at_done", bus_if.BUSY, e[0]);
      end
    end
    if (!rst_n) begin
      ex_mode = 0;
      ex_cnt  = 5;
      bus_if.EXE_RDY = 1'b0;
    end else begin
      bus_if.EXE_RDY = 1'b0;
      case (ex_mode)
        0: begin
          if (ex_cnt == 0) begin
            bus_if.EXE_RDY = 1'b1;
            ex_mode = 1;
          end else ex_cnt--;
        end
        1: begin
          if (bus_if.EXE_OP != IDLE_OP) begin
            cmd_cnt++;
            check("cmd_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("cmd", {bus_if.EXE_OP, bus_if.EXE_DATA}, e);
            end
            ex_data = bus_if.EXE_DATA;
            ex_cnt  = $urandom_range(dly_max, dly_min);
            ex_mode = 2;
          end
        end
        default: begin
          check("data_stable", bus_if.EXE_DATA, ex_data);
          if (ex_cnt == 0) begin
            bus_if.EXE_RDY = 1'b1;
            ex_mode = 1;
          end else ex_cnt--;
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic host_write(input logic [4:0] a, input logic [7:0] d);
    bus_if.WR_EN   = 1'b1;
    bus_if.WR_ADDR = a;
    bus_if.WR_DATA = d;
    mb[a] = d;
    tick();
    bus_if.WR_EN = 1'b0;
  endtask

  task automatic refresh_pulse();
    bus_if.REFRESH = 1'b1;
    tick();
    bus_if.REFRESH = 1'b0;
  endtask

  // Expected screen redraw: optional clear, then each line as address + 16 characters.
  task automatic push_seq(input logic busy_after);
`ifdef LCD_SEQ_CLEAR_EN
    exp_q.push_back({4'h0, 8'h00});
`endif
    for (int ln = 0; ln < 2; ln++) begin
      exp_q.push_back({4'h3, (ln == 0) ? 8'h00 : 8'h40});
      for (int c = 0; c < 16; c++) exp_q.push_back({4'h1, mb[ln * 16 + c]});
    end
    exp_q.push_back(MARK | {11'd0, busy_after});
  endtask

  task automatic wait_quiet(input string name, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || bus_if.BUSY) && n < limit) begin
      tick();
      n++;
    end
    check(name, n < limit, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_op"},   bus_if.EXE_OP,   IDLE_OP);
    check({tag, "_enb"},  bus_if.EXE_ENB,  1'b0);
    check({tag, "_data"}, bus_if.EXE_DATA, 8'h00);
    check({tag, "_busy"}, bus_if.BUSY,     1'b0);
    check({tag, "_done"}, bus_if.DONE,     1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c0, d0, n;
    logic found;
    bus_if.WR_EN   = 1'b0;
    bus_if.WR_ADDR = 5'd0;
    bus_if.WR_DATA = 8'h00;
    bus_if.REFRESH = 1'b0;
    for (int i = 0; i < 32; i++) mb[i] = 8'h20;

    // Reset held 3 cycles, then the executor's single init RDY parks it.
    rst_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    n = 0;
    while (dbg_state != ST_IDLE && n < 50) begin tick(); n++; end
    check("init_idle_state", dbg_state, ST_IDLE);
    check("init_enb", bus_if.EXE_ENB, 1'b1);
    check("init_no_cmd", cmd_cnt, 0);

    // HELLO on line 1 with a fixed 20-cycle executor.
    dly_min = 20; dly_max = 20;
    host_write(5'd0, "H"); host_write(5'd1, "E"); host_write(5'd2, "L");
    host_write(5'd3, "L"); host_write(5'd4, "O");
    c0 = cmd_cnt; d0 = done_cnt;
    push_seq(1'b0);
    refresh_pulse();
    wait_quiet("hello_timeout", 3000);
    tick();
    check("hello_ops", cmd_cnt - c0, N_STEPS);
    check("hello_done", done_cnt - d0, 1);
    check("hello_idle", dbg_state, ST_IDLE);

    // Random screen contents and executor latency.
    dly_min = 1; dly_max = 8;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(8, 1);
      for (int w = 0; w < n; w++)
        host_write(5'($urandom_range(31, 0)), 8'($urandom_range(8'h7E, 8'h21)));
      d0 = done_cnt;
      push_seq(1'b0);
      refresh_pulse();
      wait_quiet("rand_timeout", 2000);
      check("rand_done", done_cnt - d0, 1);
    end

    // Three extra requests during one sequence merge into one restart.
    dly_min = 2; dly_max = 5;
    d0 = done_cnt; c0 = cmd_cnt;
    push_seq(1'b1);
    push_seq(1'b0);
    refresh_pulse();
    for (int k = 0; k < 3; k++) begin
      repeat (15) tick();
      check("merge_busy", bus_if.BUSY, 1'b1);
      refresh_pulse();
    end
    wait_quiet("merge_timeout", 3000);
    tick();
    check("merge_done", done_cnt - d0, 2);
    check("merge_ops", cmd_cnt - c0, 2 * N_STEPS);
    check("merge_pending_clear", dbg_pending, 1'b0);

    // A write mid-sequence lands before its character is loaded.
    mb[20] = "Z";
    push_seq(1'b0);
    refresh_pulse();
    n = 0;
    while (dbg_step != 6'd8 && n < 500) begin tick(); n++; end
    check("z_reach_step8", dbg_step, 6'd8);
    host_write(5'd20, "Z");
    wait_quiet("z_timeout", 2000);

    // Reset during PRESENT at step 10 aborts with no DONE.
    push_seq(1'b0);
    refresh_pulse();
    found = 1'b0;
    n = 0;
    while (!found && n < 500) begin
      if (dbg_state == ST_PRESENT && dbg_step == 6'd10) found = 1'b1;
      else begin tick(); n++; end
    end
    check("abort_reach_present10", found, 1'b1);
    d0 = done_cnt;
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    check_reset_outputs("abort");
    check("abort_pending", dbg_pending, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mb[i] = 8'h20;

    // REFRESH before the executor's first RDY is held as pending.
    c0 = cmd_cnt;
    push_seq(1'b0);
    refresh_pulse();
    check("early_pending", dbg_pending, 1'b1);
    check("early_not_busy", bus_if.BUSY, 1'b0);
    wait_quiet("early_timeout", 2000);
    tick();
    check("early_ops", cmd_cnt - c0, N_STEPS);
    check("abort_no_done", done_cnt - d0, 1);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
